// File: rtl/riscv_pkg.sv
// Shared RV64 load/store definitions: funct3 codes, access sizes, lane geometry
// and the bus-bridge state encoding.
package riscv_pkg;

  localparam int BUS_BYTES  = 8;
  localparam int LANE_IDX_W = 3;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/data_bus_bridge_if.sv
// 64-bit valid/ready data bus: one request channel and one response channel.
interface data_bus_bridge_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [DATA_W/8-1:0] bus_wstrb;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational load/store lane logic: strobes, store-lane shift, load
// extract/extend and misaligned/illegal detection.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]            funct3,
  input  logic [LANE_IDX_W-1:0] addr_lo,
  input  logic                  we,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W-1:0]     rdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     wdata_lane,
  output logic [DATA_W-1:0]     load_data,
  output logic                  misaligned,
  output logic                  illegal
);

  logic [LANE_IDX_W-1:0] size_mask;
  logic [DATA_W/8-1:0]   base_strb;
  logic [DATA_W-1:0]     rshift;
  logic                  zero_ext;

  always_comb begin
    size_mask = '0;
    base_strb = '0;
    unique case (funct3[1:0])
      SZ_B: begin size_mask = 3'b000; base_strb = 8'h01; end
      SZ_H: begin size_mask = 3'b001; base_strb = 8'h03; end
      SZ_W: begin size_mask = 3'b011; base_strb = 8'h0F; end
      SZ_D: begin size_mask = 3'b111; base_strb = 8'hFF; end
    endcase

    misaligned = |(addr_lo & size_mask);
    // Unsigned variants only exist for loads; funct3 111 has no meaning at all.
    illegal    = (funct3 == F3_BAD) || (we && funct3[2]);

    wstrb      = base_strb << addr_lo;
    wdata_lane = wdata << {addr_lo, 3'b000};

    rshift    = rdata >> {addr_lo, 3'b000};
    zero_ext  = funct3[2];
    load_data = rshift;
    unique case (funct3[1:0])
      SZ_B: load_data = {{(DATA_W-8){~zero_ext & rshift[7]}},   rshift[7:0]};
      SZ_H: load_data = {{(DATA_W-16){~zero_ext & rshift[15]}}, rshift[15:0]};
      SZ_W: load_data = {{(DATA_W-32){~zero_ext & rshift[31]}}, rshift[31:0]};
      SZ_D: load_data = rshift;
    endcase
  end

endmodule

// File: rtl/data_bus_bridge.sv
// Memory-stage load/store bridge: one request becomes one valid/ready bus
// transaction, stalling the pipeline until the bus responds.
module data_bus_bridge
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_valid,
  output logic              o_fault,
  data_bus_bridge_if.master bus
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [LANE_IDX_W-1:0] addr_lo_q, addr_lo_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [DATA_W/8-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  idle;
  logic [2:0]            al_funct3;
  logic [LANE_IDX_W-1:0] al_addr_lo;
  logic                  al_we;
  logic [DATA_W/8-1:0]   al_wstrb;
  logic [DATA_W-1:0]     al_wdata_lane;
  logic [DATA_W-1:0]     al_load;
  logic                  al_misaligned, al_illegal;
  logic                  fault, accept, resp_hit;

  // One aligner serves both ends: live request fields in IDLE, latched ones afterwards.
  assign idle       = (state_q == IDLE);
  assign al_funct3  = idle ? i_funct3 : funct3_q;
  assign al_addr_lo = idle ? i_addr[LANE_IDX_W-1:0] : addr_lo_q;
  assign al_we      = idle ? i_we : we_q;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .we         (al_we),
    .wdata      (i_wdata),
    .rdata      (bus.bus_rdata),
    .wstrb      (al_wstrb),
    .wdata_lane (al_wdata_lane),
    .load_data  (al_load),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign fault    = idle && i_req && (al_misaligned || al_illegal);
  assign accept   = idle && i_req && !fault;
  assign resp_hit = ((state_q == REQ) && bus.bus_ready && bus.bus_rvalid)
                 || ((state_q == RESP) && bus.bus_rvalid);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ:  if (bus.bus_ready) state_d = bus.bus_rvalid ? DONE : RESP;
      RESP: if (bus.bus_rvalid) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_stall       = accept || (state_q == REQ) || (state_q == RESP);
    o_rdata_valid = (state_q == DONE);
    o_fault       = fault;
    bus.bus_valid = (state_q == REQ);
  end

  always_comb begin
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    if (accept) begin
      we_d        = i_we;
      funct3_d    = i_funct3;
      addr_lo_d   = i_addr[LANE_IDX_W-1:0];
      bus_addr_d  = {i_addr[ADDR_W-1:LANE_IDX_W], {LANE_IDX_W{1'b0}}};
      bus_wstrb_d = al_wstrb;
      bus_wdata_d = al_wdata_lane;
    end
    if (resp_hit) rdata_d = we_q ? '0 : al_load;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_wstrb = bus_wstrb_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Scoreboard bench for data_bus_bridge: directed cases plus randomized
// loads/stores against a byte-level reference model.
module tb_data_bus_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, we;
  logic [2:0]  f3;
  logic [63:0] addr, wdata;
  logic        o_stall, o_rdata_valid, o_fault;
  logic [63:0] o_rdata;

  always #5 clk = ~clk;

  data_bus_bridge_if bus ();

  data_bus_bridge dut (
    .i_clk         (clk),
    .i_resetn      (resetn),
    .i_req         (req),
    .i_we          (we),
    .i_funct3      (f3),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_stall       (o_stall),
    .o_rdata       (o_rdata),
    .o_rdata_valid (o_rdata_valid),
    .o_fault       (o_fault),
    .bus           (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          rdy_dly;
    int          rv_dly;
    logic [63:0] rdata;
  } resp_t;

  bus_exp_t    bus_q[$];
  resp_t       resp_q[$];
  logic [63:0] sb_q[$];
  logic [63:0] last_rdata = '0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-level) ----------------
  function automatic int size_of(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit model_fault(input logic w, input logic [2:0] f, input logic [63:0] a);
    int sz = size_of(f);
    int off = int'(a[2:0]);
    return ((off % sz) != 0) || (f == 3'b111) || (w && f[2]);
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] f, input int off);
    logic [7:0] s = '0;
    for (int k = 0; k < size_of(f); k++) s[off + k] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wlanes(input logic [2:0] f, input int off, input logic [63:0] wd);
    logic [63:0] v = '0;
    for (int k = 0; k < size_of(f); k++) v[8*(off+k) +: 8] = wd[8*k +: 8];
    return v;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f, input int off, input logic [63:0] rd);
    logic [63:0] v = '0;
    int sz = size_of(f);
    for (int k = 0; k < sz; k++) v[8*k +: 8] = rd[8*(off+k) +: 8];
    if (!f[2] && v[8*sz-1])
      for (int k = sz; k < 8; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] m = '0;
    for (int k = 0; k < 8; k++) if (s[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // ---------------- bus responder ----------------
  initial begin
    resp_t r;
    bus.bus_ready  = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.bus_ready  = 1'b0;
      bus.bus_rvalid = 1'b0;
      if (bus.bus_valid && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        for (int i = 0; i < r.rdy_dly; i++) begin
          bus.bus_rvalid = 1'($urandom % 2);
          bus.bus_rdata  = {$urandom, $urandom};
          @(negedge clk);
        end
        bus.bus_ready  = 1'b1;
        bus.bus_rvalid = (r.rv_dly == 0);
        bus.bus_rdata  = (r.rv_dly == 0) ? r.rdata : {$urandom, $urandom};
        @(negedge clk);
        bus.bus_ready  = 1'b0;
        bus.bus_rvalid = 1'b0;
        if (r.rv_dly > 0) begin
          for (int i = 0; i < r.rv_dly - 1; i++) @(negedge clk);
          bus.bus_rvalid = 1'b1;
          bus.bus_rdata  = r.rdata;
          @(negedge clk);
          bus.bus_rvalid = 1'b0;
        end
      end else if (!bus.bus_valid) begin
        bus.bus_rvalid = 1'($urandom % 2);
        bus.bus_rdata  = {$urandom, $urandom};
      end
    end
  end

  // ---------------- bus request monitor ----------------
  initial begin
    bus_exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (resetn && bus.bus_valid) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: got addr %h expected no request", bus.bus_addr);
        end else begin
          e = bus_q[0];
          chk("bus_addr", bus.bus_addr, e.addr);
          chk("bus_we", 64'(bus.bus_we), 64'(e.we));
          chk("bus_wstrb", 64'(bus.bus_wstrb), 64'(e.strb));
          if (e.we)
            chk("bus_wdata", bus.bus_wdata & lane_mask(e.strb), e.wdata & lane_mask(e.strb));
          if (bus.bus_ready) void'(bus_q.pop_front());
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (resetn) begin
        if (o_rdata_valid) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rdata_unexpected: got %h expected no completion", o_rdata);
          end else begin
            e = sb_q.pop_front();
            chk("rdata", o_rdata, e);
            last_rdata = e;
          end
        end else begin
          chk("rdata_hold", o_rdata, last_rdata);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered just after a rising edge with the DUT in IDLE; returns the same way.
  task automatic run_txn(input logic w, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input int rdy, input int rv);
    bit       flt = model_fault(w, f, a);
    int       off = int'(a[2:0]);
    int       n = 0;
    bit       done = 0;
    bus_exp_t be;
    resp_t    r;
    req = 1'b1; we = w; f3 = f; addr = a; wdata = wd;
    #1;
    chk("fault", 64'(o_fault), 64'(flt));
    if (flt) begin
      chk("fault_stall", 64'(o_stall), 64'd0);
      chk("fault_valid", 64'(bus.bus_valid), 64'd0);
      @(posedge clk); #1;
      chk("fault_hold_valid", 64'(bus.bus_valid), 64'd0);
      chk("fault_hold", 64'(o_fault), 64'd1);
      req = 1'b0;
    end else begin
      be.addr = {a[63:3], 3'b000}; be.we = w;
      be.strb = model_strb(f, off); be.wdata = model_wlanes(f, off, wd);
      bus_q.push_back(be);
      r.rdy_dly = rdy; r.rv_dly = rv; r.rdata = rd;
      resp_q.push_back(r);
      sb_q.push_back(w ? 64'd0 : model_load(f, off, rd));
      chk("req_stall", 64'(o_stall), 64'd1);
      while (!done && n < 200) begin
        @(posedge clk); #1;
        n++;
        if (o_rdata_valid) done = 1;
        else chk("wait_stall", 64'(o_stall), 64'd1);
      end
      chk("latency", 64'(n), 64'(2 + rdy + rv));
      chk("done_stall", 64'(o_stall), 64'd0);
      @(posedge clk); #1;
      req = 1'b0;
      chk("idle_after", 64'(o_rdata_valid), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] a, wd, rd;
    logic [2:0]  f, m;
    logic        w;
    bus_exp_t    be;
    resp_t       r;
    resetn = 1'b0; req = 1'b0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.bus_valid), 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);
    chk("rst_rvalid", 64'(o_rdata_valid), 64'd0);
    chk("rst_addr", bus.bus_addr, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run_txn(1'b0, 3'b011, 64'h1000, '0, 64'h0123_4567_89AB_CDEF, 0, 0);
    chk("tp_ld", o_rdata, 64'h0123_4567_89AB_CDEF);
    run_txn(1'b0, 3'b000, 64'h1003, '0, 64'h0000_0000_80FF_0000, 0, 0);
    chk("tp_lb", o_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(1'b0, 3'b100, 64'h1003, '0, 64'h0000_0000_80FF_0000, 1, 1);
    chk("tp_lbu", o_rdata, 64'h80);
    run_txn(1'b1, 3'b001, 64'h2006, 64'hBEEF, 64'h1111_2222_3333_4444, 3, 0);
    chk("tp_sh_rdata", o_rdata, 64'd0);
    chk("tp_sh_strb", 64'(bus.bus_wstrb), 64'hC0);
    chk("tp_sh_lane", 64'(bus.bus_wdata[63:48]), 64'hBEEF);
    run_txn(1'b0, 3'b010, 64'h3002, '0, '0, 0, 0);
    run_txn(1'b0, 3'b111, 64'h3000, '0, '0, 0, 0);
    run_txn(1'b1, 3'b100, 64'h3000, 64'h55, '0, 0, 0);
    run_txn(1'b0, 3'b011, 64'h5000, '0, 64'hFEDC_BA98_7654_3210, 0, 4);

    // Reset while the load waits for its response in RESP.
    req = 1'b1; we = 1'b0; f3 = 3'b011; addr = 64'h4008; wdata = '0;
    be.addr = 64'h4008; be.we = 1'b0; be.strb = 8'hFF; be.wdata = '0;
    bus_q.push_back(be);
    r.rdy_dly = 0; r.rv_dly = 3; r.rdata = 64'hDEAD_BEEF_0000_1111;
    resp_q.push_back(r);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("resp_stall", 64'(o_stall), 64'd1);
    chk("resp_valid", 64'(bus.bus_valid), 64'd0);
    req = 1'b0;
    #1;
    last_rdata = '0;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.bus_valid), 64'd0);
    chk("arst_we", 64'(bus.bus_we), 64'd0);
    chk("arst_rvalid", 64'(o_rdata_valid), 64'd0);
    chk("arst_addr", bus.bus_addr, 64'd0);
    chk("arst_strb", 64'(bus.bus_wstrb), 64'd0);
    chk("arst_wdata", bus.bus_wdata, 64'd0);
    chk("arst_rdata", o_rdata, 64'd0);
    chk("arst_stall", 64'(o_stall), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 64'(bus.bus_valid), 64'd0);
      chk("post_rst_rvalid", 64'(o_rdata_valid), 64'd0);
    end
    run_txn(1'b0, 3'b011, 64'h6000, '0, 64'h0F0E_0D0C_0B0A_0908, 1, 2);

    for (int i = 0; i < 150; i++) begin
      w  = 1'($urandom % 2);
      f  = 3'($urandom % 8);
      a  = {$urandom, $urandom};
      if ($urandom % 4 != 0) begin
        m = 3'(size_of(f) - 1);
        a[2:0] = a[2:0] & ~m;
      end
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      run_txn(w, f, a, wd, rd, int'($urandom % 4), int'($urandom % 4));
      if ($urandom % 3 == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Load/store bus bridge sitting directly downstream of the processor's memory-access stage, completing the external data-bus connection of the processor. It turns one load or store request from the memory-access stage into a single 64-bit valid/ready bus transaction. It generates byte strobes, aligns store data, and extracts and extends load data. It stalls the pipeline until the bus responds and flags misaligned or illegal accesses without touching the bus.

## Interface
- ADDR_W, 64, byte-address width
- DATA_W, 64, bus data width; fixed at 64, 8 byte lanes
- i_clk  in  1  clock; everything is synchronous to its rising edge
- i_resetn  in  1  reset, asynchronous, active-low
- i_req  in  1  memory-access stage holds a load or store (mem_read | mem_write)
- i_we  in  1  1 = store, 0 = load
- i_funct3  in  3  RV64 size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- i_addr  in  ADDR_W  byte address (ALU result)
- i_wdata  in  64  store data (rs2 value), LSB-justified
- o_stall  out  1  freeze upstream pipeline
- o_rdata  out  64  aligned, extended load result
- o_rdata_valid  out  1  one-cycle pulse, transaction complete (loads and stores)
- o_fault  out  1  misaligned or illegal access, no bus activity
- o_bus_valid  out  1  request valid
- i_bus_ready  in  1  request accepted
- o_bus_addr  out  ADDR_W  i_addr with bits [2:0] cleared
- o_bus_we  out  1  write request
- o_bus_wstrb  out  8  byte-lane strobes
- o_bus_wdata  out  64  lane-shifted store data
- i_bus_rvalid  in  1  response (read data or write ack)
- i_bus_rdata  in  64  read data

## Operation
- States:
  - IDLE: on i_req && !fault, register addr/we/funct3/wdata and go to REQ.
  - REQ: o_bus_valid = 1. On i_bus_ready go to RESP, or straight to DONE if i_bus_rvalid is also high that cycle.
  - RESP: on i_bus_rvalid, capture data and go to DONE.
  - DONE: o_rdata_valid = 1, then go to IDLE.
- Size is 1 << funct3[1:0] bytes. Misaligned when the addr bits below the size are nonzero. Illegal: funct3 = 111; store with funct3[2] = 1.
- o_fault = IDLE && i_req && (misaligned | illegal), combinational. In that case the state does not change and o_stall = 0.
- Strobe: (1 << size) - 1, shifted left by addr[2:0].
- Write data: i_wdata << (8 × addr[2:0]); lanes outside the strobe carry don't-care.
- Load: i_bus_rdata >> (8 × addr[2:0]), truncated to size, then sign-extended (funct3[2] = 0) or zero-extended (funct3[2] = 1). o_rdata is 0 for stores.
- o_stall = (IDLE && i_req && !fault) | REQ | RESP.
- i_req is ignored in DONE, because it is the same instruction. A new request is sampled in IDLE.
- i_bus_rvalid is ignored in IDLE and DONE, and in REQ without i_bus_ready.

## Timing
- Reset (asynchronous, mid-transaction included): state to IDLE. o_bus_valid, o_bus_we, o_rdata_valid go to 0. o_bus_addr, o_bus_wstrb, o_bus_wdata, o_rdata go to 0. Any outstanding bus transaction is abandoned.
- Bus address/we/strobe/data come from registers. They must be stable while o_bus_valid = 1 && !i_bus_ready.
- Minimum latency, with ready and rvalid both in the first REQ cycle:
  - request cycle: stall = 1
  - REQ cycle: stall = 1
  - DONE cycle: stall = 0, o_rdata_valid = 1
- Each wait cycle of ready or rvalid adds one stall cycle.
- o_rdata holds its value after DONE until the next completion.

## Structure
- Shared riscv_pkg holds:
  - funct3 load/store constants
  - state enum {IDLE, REQ, RESP, DONE}
  - size and lane-count constants
- One combinational sub-module, lsu_align, computes strobe, store-lane shift, load extract/extend, and misaligned/illegal detection. It is reused later by the fetch path.

## Test plan
- LD at 0x1000; bus rdata 0x0123_4567_89AB_CDEF with ready + rvalid on the first REQ cycle -> stall 2 cycles, then o_rdata = 0x0123456789ABCDEF and o_rdata_valid for 1 cycle.
- LB at 0x1003 with rdata 0x0000_0000_80FF_0000 -> o_bus_addr 0x1000, o_rdata 0xFFFF_FFFF_FFFF_FF80. Same access as LBU -> o_rdata 0x80.
- SH at 0x2006 with wdata 0xBEEF -> wstrb 0xC0, wdata[63:48] = 0xBEEF, o_bus_we = 1. Ready delayed 3 cycles -> valid, addr and data stable throughout.
- LW at 0x3002 -> o_fault = 1, no o_bus_valid, o_stall = 0. Also funct3 = 111 -> o_fault = 1.
- LD where ready arrives on cycle 1 and rvalid 4 cycles later -> stall through RESP. An rvalid asserted in IDLE beforehand is ignored.
- Reset asserted while in RESP -> outputs zero immediately. After release, a fresh LD completes normally.
